// File: rtl/vector_dot_accumulator.sv
// ============================================================================
//  Module   : vector_dot_accumulator
//  Brief    : Sums four 16-bit lane products per beat and accumulates BEATS
//             beats into one dot product, returned over valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_dot_accumulator #(
    parameter int BEATS = 4,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [15:0]      product1,
    input  logic [15:0]      product2,
    input  logic [15:0]      product3,
    input  logic [15:0]      product4,
    output logic             in_ready,
    output logic             busy,
    output logic [ACC_W-1:0] result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic               r_overflow;
    logic [17:0]        w_lane_sum;
    logic [ACC_W:0]     w_acc_sum;
    logic               w_accept;
    logic               w_last_beat;

    // 18 bits holds four full-scale 16-bit products without truncation.
    assign w_lane_sum  = 18'(product1) + 18'(product2) + 18'(product3) + 18'(product4);
    assign w_acc_sum   = {1'b0, r_acc} + {{(ACC_W + 1 - 18){1'b0}}, w_lane_sum};
    assign w_accept    = (r_state == S_ACCUM) && in_valid;
    assign w_last_beat = (r_beat_cnt == C_LAST_BEAT);

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_ACCUM;
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && w_last_beat) w_state_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && start) begin
                r_acc      <= '0;
                r_beat_cnt <= '0;
                r_overflow <= 1'b0;
            end else if (w_accept) begin
                r_acc      <= w_acc_sum[ACC_W-1:0];
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                if (w_acc_sum[ACC_W]) r_overflow <= 1'b1;
            end
        end
    end

    assign result   = r_acc;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_vector_dot_accumulator.sv
// ============================================================================
//  Module   : tb_vector_dot_accumulator
//  Brief    : Randomised scoreboard bench for vector_dot_accumulator, using a
//             default instance and an 18-bit/2-beat instance for wrap cases.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_dot_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_m = 1'b0;
    logic        start_o = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] product1 = '0, product2 = '0, product3 = '0, product4 = '0;
    logic        out_ready = 1'b1;
    logic [1:0]  in_ready_v, busy_v, out_valid_v, overflow_v;
    logic [31:0] res_m;
    logic [17:0] res_o;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vector_dot_accumulator #(.BEATS(4), .ACC_W(32)) u_dut_main (
        .clk(clk), .reset(reset), .start(start_m), .in_valid(in_valid),
        .product1(product1), .product2(product2), .product3(product3), .product4(product4),
        .in_ready(in_ready_v[0]), .busy(busy_v[0]), .result(res_m),
        .out_valid(out_valid_v[0]), .out_ready(out_ready), .overflow(overflow_v[0])
    );

    vector_dot_accumulator #(.BEATS(2), .ACC_W(18)) u_dut_wrap (
        .clk(clk), .reset(reset), .start(start_o), .in_valid(in_valid),
        .product1(product1), .product2(product2), .product3(product3), .product4(product4),
        .in_ready(in_ready_v[1]), .busy(busy_v[1]), .result(res_o),
        .out_valid(out_valid_v[1]), .out_ready(out_ready), .overflow(overflow_v[1])
    );

    function automatic logic [31:0] res(input int s);
        return (s == 0) ? res_m : {14'd0, res_o};
    endfunction

    task automatic chk(input string name, input int s, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut=%0d actual=%0h expected=%0h t=%0t", name, s, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 0) start_m = v;
        else        start_o = v;
    endtask

    // Output monitor: compares every presented result against the queue head
    task automatic mon(input int s);
        exp_t e;
        bit   empty;
        empty = (s == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (out_valid_v[s]) begin
            if (empty) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out dut=%0d actual=%0h expected=none", s, res(s));
            end else begin
                e = (s == 0) ? q0[0] : q1[0];
                chk("out_result", s, 64'(res(s)), 64'(e.res));
                chk("out_overflow", s, 64'(overflow_v[s]), 64'(e.ovf));
                chk("done_in_ready", s, 64'(in_ready_v[s]), 64'd0);
                if (out_ready) begin
                    if (s == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon(0);
            mon(1);
        end
    end

    // mode: 0 random, 1 lanes 1/2/3/4, 2 all 0xFE01, 3 all ones
    task automatic run(input int s, input int mode, input int stall_at, input int stall_len,
                       input int bp_len, input bit poke);
        int          nb;
        int          accw;
        logic [15:0] p[4][4];
        logic [63:0] total;
        exp_t        e;
        nb    = (s == 0) ? 4 : 2;
        accw  = (s == 0) ? 32 : 18;
        total = '0;
        for (int b = 0; b < 4; b++) begin
            for (int l = 0; l < 4; l++) begin
                case (mode)
                    0:       p[b][l] = 16'($urandom_range(0, 65535));
                    1:       p[b][l] = 16'(l + 1);
                    2:       p[b][l] = 16'hFE01;
                    default: p[b][l] = 16'd1;
                endcase
                if (b < nb) total += 64'(p[b][l]);
            end
        end
        e.res = 32'(total & ((64'd1 << accw) - 64'd1));
        e.ovf = (total >> accw) != 64'd0;
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);

        set_start(s, 1'b1);
        tick();
        set_start(s, 1'b0);
        chk("start_in_ready", s, 64'(in_ready_v[s]), 64'd1);
        chk("start_result", s, 64'(res(s)), 64'd0);
        chk("start_overflow", s, 64'(overflow_v[s]), 64'd0);

        for (int b = 0; b < nb; b++) begin
            if (b == stall_at) begin
                for (int k = 0; k < stall_len; k++) begin
                    in_valid = 1'b0;
                    set_start(s, poke);
                    tick();
                    set_start(s, 1'b0);
                end
            end
            in_valid = 1'b1;
            product1 = p[b][0];
            product2 = p[b][1];
            product3 = p[b][2];
            product4 = p[b][3];
            tick();
            if (b < nb - 1) chk("accum_out_valid", s, 64'(out_valid_v[s]), 64'd0);
        end
        in_valid = 1'b0;
        chk("done_out_valid", s, 64'(out_valid_v[s]), 64'd1);
        chk("done_busy", s, 64'(busy_v[s]), 64'd1);

        for (int k = 0; k < bp_len; k++) begin
            out_ready = 1'b0;
            in_valid  = poke;
            {product1, product2, product3, product4} = {4{16'hFFFF}};
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_start(s, poke);
        tick();
        set_start(s, 1'b0);
        chk("idle_out_valid", s, 64'(out_valid_v[s]), 64'd0);
        chk("idle_busy", s, 64'(busy_v[s]), 64'd0);
        chk("idle_in_ready", s, 64'(in_ready_v[s]), 64'd0);

        if (poke) begin
            in_valid = 1'b1;
            {product1, product2, product3, product4} = {4{16'hFFFF}};
            tick();
            tick();
            in_valid = 1'b0;
            chk("idle_ignore_busy", s, 64'(busy_v[s]), 64'd0);
            chk("idle_ignore_result", s, 64'(res(s)), 64'(e.res));
        end
    endtask

    task automatic check_reset_state();
        for (int s = 0; s < 2; s++) begin
            chk("rst_result", s, 64'(res(s)), 64'd0);
            chk("rst_overflow", s, 64'(overflow_v[s]), 64'd0);
            chk("rst_out_valid", s, 64'(out_valid_v[s]), 64'd0);
            chk("rst_in_ready", s, 64'(in_ready_v[s]), 64'd0);
            chk("rst_busy", s, 64'(busy_v[s]), 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check_reset_state();

        run(0, 1, -1, 0, 0, 1'b0);
        run(0, 2, -1, 0, 0, 1'b0);
        run(0, 1, 2, 3, 5, 1'b1);
        run(1, 2, -1, 0, 2, 1'b0);
        run(1, 3, -1, 0, 0, 1'b0);

        // Abandon a run after two beats; no expectation is queued for it.
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1;
            {product1, product2, product3, product4} = {4{16'h1234}};
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        check_reset_state();
        run(0, 1, -1, 0, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run(i % 2, 0, $urandom_range(0, 3), $urandom_range(0, 2),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        tick();
        chk("queue_drained", 0, 64'(q0.size()), 64'd0);
        chk("queue_drained", 1, 64'(q1.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
